branch_gshare_spec: RTL
=======================

BRANCH_GSHARE_SPEC -- requirements
Module: branch_gshare_spec

Interface
REQ-001 SHALL have parameter IDX_W, default 8: PHT index width; the PHT holds 2^IDX_W entries.
REQ-002 SHALL have parameter HIST_W, default 8: global history length; legal range 1..IDX_W.
REQ-003 SHALL have parameter CNT_W, default 2: counter width; legal range 2..4.
REQ-004 SHALL have parameter INIT_CNT, default 1: counter value written during init; default is weak-not-taken.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pc_if, input, 32 bits: fetch PC.
REQ-008 SHALL have port if_valid, input, 1 bit: a branch-like instruction is fetched this cycle.
REQ-009 SHALL have port pred_taken_if, output, 1 bit: prediction; the counter MSB.
REQ-010 SHALL have port pht_idx_if, output, IDX_W bits: hashed index, carried to EX.
REQ-011 SHALL have port ghr_snap_if, output, HIST_W bits: speculative GHR value before this fetch's shift, carried to EX.
REQ-012 SHALL have port ready, output, 1 bit: init sweep complete.
REQ-013 SHALL have port ex_update_en, input, 1 bit: a branch resolves this cycle.
REQ-014 SHALL have port ex_actual_taken, input, 1 bit: resolved outcome.
REQ-015 SHALL have port ex_mispredict, input, 1 bit: resolved outcome differs from the prediction; qualified by ex_update_en.
REQ-016 SHALL have port pht_idx_ex, input, IDX_W bits: index returned from IF.
REQ-017 SHALL have port ghr_snap_ex, input, HIST_W bits: snapshot returned from IF.
REQ-018 SHALL have port mispred_cnt, output, 16 bits: saturating mispredict count.

Function
REQ-019 SHALL compute pht_idx_if combinationally as pc_if[IDX_W+1:2] XOR the zero-extended ghr_spec (history in the low bits).
REQ-020 SHALL drive pred_taken_if from the MSB of pht[pht_idx_if] when ready=1, and SHALL force it to 0 when ready=0.
REQ-021 SHALL drive ghr_snap_if equal to the current ghr_spec.
REQ-022 SHALL maintain two histories: ghr_spec (speculative) and ghr_arch (committed), both HIST_W bits.
REQ-023 SHALL shift the predicted direction into ghr_spec ({ghr_spec[HIST_W-2:0], pred_taken_if}) when if_valid=1 and ready=1; when HIST_W=1, ghr_spec SHALL take pred_taken_if.
REQ-024 SHALL shift ex_actual_taken into ghr_arch when ex_update_en=1 and ready=1.
REQ-025 SHALL, when ex_update_en=1, ex_mispredict=1 and ready=1, load ghr_spec with {ghr_snap_ex[HIST_W-2:0], ex_actual_taken}; this repair SHALL take priority over a same-cycle IF shift, and the IF shift SHALL be dropped.
REQ-026 SHALL, on ex_update_en=1 and ready=1, increment pht[pht_idx_ex] when taken (saturating at 2^CNT_W-1) and decrement it when not taken (saturating at 0).
REQ-027 SHALL make PHT writes visible from the next cycle; a same-cycle read of the same index SHALL return the old value.
REQ-028 SHALL increment mispred_cnt on each ex_update_en & ex_mispredict while ready=1, saturating at 0xFFFF.
REQ-029 SHALL implement an FSM with states INIT and RUN.
REQ-030 SHALL, in INIT, write INIT_CNT to one PHT entry per cycle at the address held in a sweep counter (0 upward), hold ready=0, and ignore if_valid, ex_update_en and ex_mispredict.
REQ-031 SHALL transition INIT->RUN in the cycle after entry 2^IDX_W-1 is written; ready SHALL rise in that cycle, 2^IDX_W cycles after reset release (256 by default).
REQ-032 SHALL remain in RUN until rst is asserted.
REQ-033 SHALL NOT give the PHT array an asynchronous reset; initialisation is by the sweep only.

Reset
REQ-034 SHALL, on rst assertion, immediately set FSM=INIT, sweep counter=0, ghr_spec=0, ghr_arch=0, mispred_cnt=0, ready=0, and pred_taken_if=0.
REQ-035 SHALL, on rst asserted mid-sweep or mid-RUN, restart the sweep from entry 0 after release and discard all prior training.

Verification
REQ-036 Reset release, defaults -> ready=0 for exactly 256 cycles, then 1; pred_taken_if=0 for every pc_if.
REQ-037 After init, 3 taken updates on index 0x05 -> counter sequence 1->2->3->3; pred_taken_if=1 for a pc/GHR hashing to 0x05.
REQ-038 ghr_spec=0x00, if_valid with prediction 1 three times -> ghr_snap_if=0x07; then mispredict with ghr_snap_ex=0x01, actual=0 -> ghr_spec=0x02 next cycle, and a same-cycle if_valid shift is dropped.
REQ-039 mispred_cnt preloaded by 65535 mispredicts, then one more -> stays 0xFFFF.
REQ-040 rst pulsed at sweep entry 100 -> ready rises 256 cycles after the second release; ex_update_en pulses during INIT leave the PHT, GHRs and mispred_cnt unchanged.
REQ-041 IDX_W=10, HIST_W=4, CNT_W=3: 7 decrements from 1 -> counter 0 (saturates); 8 increments -> 7; init lasts 1024 cycles.

Source files
------------

// File: rtl/branch_gshare_spec.sv
// -----------------------------------------------------------------------------
// branch_gshare_spec
// Gshare branch direction predictor. A pattern history table (PHT) of
// saturating counters is indexed by PC bits XOR a speculative global history.
// After reset an init sweep writes INIT_CNT to every PHT entry, one per cycle,
// before the predictor reports ready.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   pc_if, if_valid   : fetch PC and fetch-of-branch strobe
//   pred_taken_if     : predicted direction (counter MSB, 0 while not ready)
//   pht_idx_if        : hashed PHT index, carried down the pipe to EX
//   ghr_snap_if       : speculative history before this fetch's shift
//   ready             : init sweep complete
//   ex_update_en      : a branch resolves this cycle
//   ex_actual_taken   : resolved direction
//   ex_mispredict     : resolved direction differs from the prediction
//   pht_idx_ex        : index returned from IF
//   ghr_snap_ex       : history snapshot returned from IF
//   mispred_cnt       : saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_gshare_spec #(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_CNT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_if,
  input  logic              if_valid,
  output logic              pred_taken_if,
  output logic [IDX_W-1:0]  pht_idx_if,
  output logic [HIST_W-1:0] ghr_snap_if,
  output logic              ready,
  input  logic              ex_update_en,
  input  logic              ex_actual_taken,
  input  logic              ex_mispredict,
  input  logic [IDX_W-1:0]  pht_idx_ex,
  input  logic [HIST_W-1:0] ghr_snap_ex,
  output logic [15:0]       mispred_cnt
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);
  localparam logic [15:0]      MCNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  sweep_q;
  logic              ready_q;

  logic [HIST_W-1:0] ghr_spec_q, ghr_spec_d;
  logic [HIST_W-1:0] ghr_arch_q, ghr_arch_d;
  logic [15:0]       mispred_cnt_q, mispred_cnt_d;

  logic [CNT_W-1:0]  pht_q [DEPTH];

  logic [CNT_W-1:0]  cnt_rd_if_c;
  logic [CNT_W-1:0]  cnt_ex_old_c;
  logic [CNT_W-1:0]  cnt_ex_new_c;
  logic              upd_c;
  logic              repair_c;
  logic              shift_c;

  // PC bits outside the index field do not take part in the hash
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[31:IDX_W+2], pc_if[1:0]};

  // Init sweep / run control; ready rises together with the move to RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + IDX_W'(1);
          if (&sweep_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // All training is gated by ready so INIT ignores EX and IF activity
  assign upd_c    = ready_q & ex_update_en;
  assign repair_c = upd_c & ex_mispredict;
  assign shift_c  = ready_q & if_valid;

  // Fetch-side hash and prediction
  assign pht_idx_if    = pc_if[IDX_W+1:2] ^ IDX_W'(ghr_spec_q);
  assign cnt_rd_if_c   = pht_q[pht_idx_if];
  assign pred_taken_if = ready_q & cnt_rd_if_c[CNT_W-1];
  assign ghr_snap_if   = ghr_spec_q;

  // Saturating counter step for the resolving branch
  assign cnt_ex_old_c = pht_q[pht_idx_ex];

  always_comb begin
    cnt_ex_new_c = cnt_ex_old_c;
    if (ex_actual_taken) begin
      if (cnt_ex_old_c != CNT_MAX) cnt_ex_new_c = cnt_ex_old_c + CNT_W'(1);
    end else begin
      if (cnt_ex_old_c != '0) cnt_ex_new_c = cnt_ex_old_c - CNT_W'(1);
    end
  end

  // PHT storage: no reset, contents come from the sweep; reads see the old value
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      pht_q[sweep_q] <= CNT_INIT;
    end else if (upd_c) begin
      pht_q[pht_idx_ex] <= cnt_ex_new_c;
    end
  end

  // History and statistics next state; a mispredict repair overrides the IF shift.
  // The width cast keeps the low HIST_W bits of {history, new_bit}, which is the
  // left shift for HIST_W>1 and just new_bit for HIST_W==1.
  always_comb begin
    ghr_spec_d    = ghr_spec_q;
    ghr_arch_d    = ghr_arch_q;
    mispred_cnt_d = mispred_cnt_q;
    if (repair_c) begin
      ghr_spec_d = HIST_W'({ghr_snap_ex, ex_actual_taken});
    end else if (shift_c) begin
      ghr_spec_d = HIST_W'({ghr_spec_q, pred_taken_if});
    end
    if (upd_c) begin
      ghr_arch_d = HIST_W'({ghr_arch_q, ex_actual_taken});
    end
    if (repair_c && (mispred_cnt_q != MCNT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_spec_q    <= '0;
      ghr_arch_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_spec_q    <= ghr_spec_d;
      ghr_arch_q    <= ghr_arch_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign ready       = ready_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
